// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage register: occupancy codes and
// performance counter width/limit.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int PERF_W = 32;
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    // State values double as the reported occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side (in_*)
// and downstream side (out_*). The stage itself uses the slave modport.
interface pipe_stage_reg_if #(parameter int DATA_W = 32);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_stage_reg_sat_cnt.sv
// Saturating PERF_W-bit event counter, cleared only by reset.
module pipe_sat_cnt
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    output logic [PERF_W-1:0] o_count
);

    logic [PERF_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != PERF_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush and bubble zeroing.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter bit BUBBLE_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_reg_if.slave   bus,
    output logic [1:0]        occ,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_bubble
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_fire;
    logic w_out_fire;
    logic w_out_valid;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_clear_main;
    logic w_clear_skid;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = bus.in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Flush overrides everything, including an input offered in the same cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear_main     = 1'b0;
        w_clear_skid     = 1'b0;
        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_clear_main = 1'b1;
            w_clear_skid = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt  = ST_EMPTY;
                        w_clear_main = BUBBLE_ZERO;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                        w_clear_skid     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = ST_EMPTY;
                    w_clear_main = 1'b1;
                    w_clear_skid = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_clear_main) begin
                r_main_data <= '0;
            end else if (w_load_main_in) begin
                r_main_data <= bus.in_data;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
            end

            if (w_clear_skid) begin
                r_skid_data <= '0;
            end else if (w_load_skid) begin
                r_skid_data <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_data;
    assign occ           = r_state;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_out_valid & ~bus.out_ready),
        .o_count (perf_stall)
    );

    pipe_sat_cnt u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (~w_out_valid & bus.out_ready),
        .o_count (perf_bubble)
    );
`else
    assign perf_stall  = '0;
    assign perf_bubble = '0;
`endif

endmodule
